// File: rtl/mmio_io_controller_if.sv
// CPU-side load/store port of the memory-mapped I/O block.
// The CPU drives the address and strobes; the block answers with
// combinational read data and a hit flag for the region decoder.
interface mmio_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             wr_en;
    logic             rd_en;
    logic [DBITS-1:0] wdata;
    logic [DBITS-1:0] rdata;
    logic             sel;

    modport master (output addr, wr_en, rd_en, wdata, input rdata, sel);
    modport slave  (input addr, wr_en, rd_en, wdata, output rdata, sel);
endinterface

// File: rtl/mmio_io_controller.sv
// Memory-mapped I/O controller: synchronised keys and debounced switches
// with Ready/Overrun status, LED/HEX output registers, a tick-based timer
// and one registered interrupt line.
// Device index in the status vectors: 0 = keys, 1 = switches, 2 = timer.
module mmio_io_controller #(
    parameter int DBITS           = 32,
    parameter int KEY_BITS        = 4,
    parameter int SW_BITS         = 10,
    parameter int LEDR_BITS       = 10,
    parameter int LEDG_BITS       = 8,
    parameter int HEX_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int TICK_CYCLES     = 50000,
    parameter logic [DBITS-1:0] ADDR_HEX   = 32'hF000_0000,
    parameter logic [DBITS-1:0] ADDR_LEDR  = 32'hF000_0004,
    parameter logic [DBITS-1:0] ADDR_LEDG  = 32'hF000_0008,
    parameter logic [DBITS-1:0] ADDR_KDATA = 32'hF000_0010,
    parameter logic [DBITS-1:0] ADDR_KCTRL = 32'hF000_0110,
    parameter logic [DBITS-1:0] ADDR_SDATA = 32'hF000_0014,
    parameter logic [DBITS-1:0] ADDR_SCTRL = 32'hF000_0114,
    parameter logic [DBITS-1:0] ADDR_TCNT  = 32'hF000_0020,
    parameter logic [DBITS-1:0] ADDR_TLIM  = 32'hF000_0024,
    parameter logic [DBITS-1:0] ADDR_TCTRL = 32'hF000_0120
) (
    input  logic                    clk,
    input  logic                    reset,
    mmio_if.slave                   bus,
    output logic                    irq,
    input  logic [KEY_BITS-1:0]     key_in,
    input  logic [SW_BITS-1:0]      sw_in,
    output logic [LEDR_BITS-1:0]    ledr,
    output logic [LEDG_BITS-1:0]    ledg,
    output logic [4*HEX_DIGITS-1:0] hex
);
    localparam int HEX_BITS = 4 * HEX_DIGITS;
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_CYCLES - 1);

    logic hit_hex, hit_ledr, hit_ledg, hit_kdata, hit_kctrl;
    logic hit_sdata, hit_sctrl, hit_tcnt, hit_tlim, hit_tctrl;

    // Keys are inverted on the way in so the flops (and KDATA) reset to
    // "nothing pressed"; key_s2 is KDATA itself.
    logic [KEY_BITS-1:0] key_s1, key_s2, key_prev;
    logic [SW_BITS-1:0]  sw_s1, sw_s2, sw_last, sdata;
    logic [DB_W-1:0]     db_cnt;
    logic [PS_W-1:0]     presc;
    logic [DBITS-1:0]    tcnt, tlim;
    logic                key_evt, sw_evt, tmr_evt, tmr_wr, tick;

    logic [2:0] rdy, ovr, ie;
    logic [2:0] evt, ctrl_wr, data_rd, clr_rdy, clr_ovr;

    // Exact-match register decode
    always_comb begin
        hit_hex   = (bus.addr == ADDR_HEX);
        hit_ledr  = (bus.addr == ADDR_LEDR);
        hit_ledg  = (bus.addr == ADDR_LEDG);
        hit_kdata = (bus.addr == ADDR_KDATA);
        hit_kctrl = (bus.addr == ADDR_KCTRL);
        hit_sdata = (bus.addr == ADDR_SDATA);
        hit_sctrl = (bus.addr == ADDR_SCTRL);
        hit_tcnt  = (bus.addr == ADDR_TCNT);
        hit_tlim  = (bus.addr == ADDR_TLIM);
        hit_tctrl = (bus.addr == ADDR_TCTRL);
    end

    assign bus.sel = hit_hex | hit_ledr | hit_ledg | hit_kdata | hit_kctrl |
                     hit_sdata | hit_sctrl | hit_tcnt | hit_tlim | hit_tctrl;

    // Two-flop synchronisers and previous KDATA for change detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1   <= '0;
            key_s2   <= '0;
            key_prev <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
        end else begin
            key_s1   <= ~key_in;
            key_s2   <= key_s1;
            key_prev <= key_s2;
            sw_s1    <= sw_in;
            sw_s2    <= sw_s1;
        end
    end

    assign key_evt = (key_s2 != key_prev);
    assign sw_evt  = (sw_s2 == sw_last) && (db_cnt == DB_LAST) && (sw_last != sdata);

    // Switch debounce: stable-cycle counter saturates at DB_LAST
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_last <= '0;
            db_cnt  <= '0;
            sdata   <= '0;
        end else begin
            sw_last <= sw_s2;
            if (sw_s2 != sw_last)
                db_cnt <= '0;
            else if (db_cnt != DB_LAST)
                db_cnt <= db_cnt + DB_W'(1);
            if (sw_evt)
                sdata <= sw_last;
        end
    end

    // A timer write restarts the prescaler and overrides that cycle's tick.
    assign tmr_wr  = bus.wr_en & (hit_tcnt | hit_tlim);
    assign tick    = (presc == PS_LAST) & ~tmr_wr;
    assign tmr_evt = tick && (tlim != '0) && (tcnt == tlim - DBITS'(1));

    // Prescaler, tick counter and limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            tcnt  <= '0;
            tlim  <= '0;
        end else begin
            if (tmr_wr || presc == PS_LAST)
                presc <= '0;
            else
                presc <= presc + PS_W'(1);

            if (bus.wr_en && hit_tcnt)
                tcnt <= bus.wdata;
            else if (tmr_evt)
                tcnt <= '0;
            else if (tick && tlim != '0)
                tcnt <= tcnt + DBITS'(1);

            if (bus.wr_en && hit_tlim)
                tlim <= bus.wdata;
        end
    end

    // Status clear sources; an event in the same cycle takes precedence.
    always_comb begin
        evt     = {tmr_evt, sw_evt, key_evt};
        ctrl_wr = {hit_tctrl, hit_sctrl, hit_kctrl} & {3{bus.wr_en}};
        data_rd = {1'b0, hit_sdata, hit_kdata} & {3{bus.rd_en}};
        clr_rdy = data_rd | (ctrl_wr & {3{~bus.wdata[0]}});
        clr_ovr = ctrl_wr & {3{~bus.wdata[2]}};
    end

    // Ready / Overrun / IE bits and the registered interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy <= '0;
            ovr <= '0;
            ie  <= '0;
            irq <= 1'b0;
        end else begin
            rdy <= evt | (rdy & ~clr_rdy);
            ovr <= (evt & rdy & ~clr_rdy) | (ovr & ~clr_ovr);
            ie  <= (ctrl_wr & {3{bus.wdata[8]}}) | (ie & ~ctrl_wr);
            irq <= |(rdy & ie);
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex  <= '0;
            ledr <= '0;
            ledg <= '0;
        end else if (bus.wr_en) begin
            if (hit_hex)  hex  <= bus.wdata[HEX_BITS-1:0];
            if (hit_ledr) ledr <= bus.wdata[LEDR_BITS-1:0];
            if (hit_ledg) ledg <= bus.wdata[LEDG_BITS-1:0];
        end
    end

    // Combinational read mux, zero-extended, 0 for unmapped addresses
    always_comb begin
        bus.rdata = '0;
        if (hit_hex)        bus.rdata[HEX_BITS-1:0]  = hex;
        else if (hit_ledr)  bus.rdata[LEDR_BITS-1:0] = ledr;
        else if (hit_ledg)  bus.rdata[LEDG_BITS-1:0] = ledg;
        else if (hit_kdata) bus.rdata[KEY_BITS-1:0]  = key_s2;
        else if (hit_sdata) bus.rdata[SW_BITS-1:0]   = sdata;
        else if (hit_tcnt)  bus.rdata                = tcnt;
        else if (hit_tlim)  bus.rdata                = tlim;
        else if (hit_kctrl) begin
            bus.rdata[0] = rdy[0];
            bus.rdata[2] = ovr[0];
            bus.rdata[8] = ie[0];
        end else if (hit_sctrl) begin
            bus.rdata[0] = rdy[1];
            bus.rdata[2] = ovr[1];
            bus.rdata[8] = ie[1];
        end else if (hit_tctrl) begin
            bus.rdata[0] = rdy[2];
            bus.rdata[2] = ovr[2];
            bus.rdata[8] = ie[2];
        end
    end
endmodule

// File: tb/tb_mmio_io_controller.sv
// Scoreboard bench for mmio_io_controller: a cycle-level reference model
// of the register map predicts every load; a monitor compares loads and pins.
module tb_mmio_io_controller;
    localparam int DBITS = 32;
    localparam int KB    = 4;
    localparam int SWB   = 10;
    localparam int DEB   = 8;
    localparam int TICK  = 4;

    localparam logic [31:0] A_HEX   = 32'hF000_0000;
    localparam logic [31:0] A_LEDR  = 32'hF000_0004;
    localparam logic [31:0] A_LEDG  = 32'hF000_0008;
    localparam logic [31:0] A_KDATA = 32'hF000_0010;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SDATA = 32'hF000_0014;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;
    localparam logic [31:0] A_TCNT  = 32'hF000_0020;
    localparam logic [31:0] A_TLIM  = 32'hF000_0024;
    localparam logic [31:0] A_TCTRL = 32'hF000_0120;
    localparam logic [31:0] A_NONE  = 32'hF000_0030;

    localparam logic [31:0] CTRL_A [3] = '{A_KCTRL, A_SCTRL, A_TCTRL};
    localparam logic [31:0] DATA_A [3] = '{A_KDATA, A_SDATA, A_NONE};
    localparam logic [31:0] ADDRS [12] = '{A_HEX, A_LEDR, A_LEDG, A_KDATA, A_KCTRL, A_SDATA,
                                           A_SCTRL, A_TCNT, A_TLIM, A_TCTRL, A_NONE, 32'hF000_0001};

    typedef struct {
        logic [31:0] a;
        logic [31:0] val;
        logic        sel;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic irq;
    logic [KB-1:0]  key_in;
    logic [SWB-1:0] sw_in;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [15:0] hex;

    mmio_if #(.DBITS(DBITS)) bus ();

    mmio_io_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES(TICK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .irq(irq),
        .key_in(key_in),
        .sw_in(sw_in),
        .ledr(ledr),
        .ledg(ledg),
        .hex(hex)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    exp_t exp_q[$];

    // Reference model state (value of each register after the latest edge)
    int n_edge, last_w;
    logic [KB-1:0]  m_pr_last, m_kd_cur, m_kd_old;
    logic [SWB-1:0] sw_hist[$];
    logic [SWB-1:0] m_sdata;
    logic [31:0] m_tcnt, m_tlim;
    logic [2:0]  m_rdy, m_ovr, m_ie;
    logic        m_irq;
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ctrl_word(input int i);
        return (32'(m_ie[i]) << 8) | (32'(m_ovr[i]) << 2) | 32'(m_rdy[i]);
    endfunction

    function automatic exp_t model_read(input logic [31:0] a);
        exp_t e;
        e.a = a;
        e.sel = 1'b1;
        case (a)
            A_HEX:   e.val = 32'(m_hex);
            A_LEDR:  e.val = 32'(m_ledr);
            A_LEDG:  e.val = 32'(m_ledg);
            A_KDATA: e.val = 32'(m_kd_cur);
            A_SDATA: e.val = 32'(m_sdata);
            A_TCNT:  e.val = m_tcnt;
            A_TLIM:  e.val = m_tlim;
            A_KCTRL: e.val = ctrl_word(0);
            A_SCTRL: e.val = ctrl_word(1);
            A_TCTRL: e.val = ctrl_word(2);
            default: begin e.val = 32'h0; e.sel = 1'b0; end
        endcase
        return e;
    endfunction

    task automatic model_step();
        logic [2:0] ev;
        logic [SWB-1:0] v;
        logic stable, wr_t;
        n_edge++;
        m_irq = |(m_rdy & m_ie);
        // keys: KDATA follows the pressed state one edge behind the first flop
        ev[0] = (m_kd_cur != m_kd_old);
        m_kd_old  = m_kd_cur;
        m_kd_cur  = m_pr_last;
        m_pr_last = ~key_in;
        // switches: accepted once the last DEB+1 synchronised samples agree
        sw_hist.push_back(sw_in);
        while (sw_hist.size() > DEB + 3) void'(sw_hist.pop_front());
        v = sw_hist[0];
        stable = 1'b1;
        for (int i = 0; i <= DEB; i++) if (sw_hist[i] != v) stable = 1'b0;
        ev[1] = stable && (v != m_sdata);
        if (ev[1]) m_sdata = v;
        // timer: ticks every TICK edges counted from the last timer write
        wr_t = bus.wr_en && (bus.addr == A_TCNT || bus.addr == A_TLIM);
        ev[2] = 1'b0;
        if (!wr_t && ((n_edge - last_w) % TICK == 0) && m_tlim != 0) begin
            if (m_tcnt == m_tlim - 1) begin
                m_tcnt = 0;
                ev[2] = 1'b1;
            end else begin
                m_tcnt = m_tcnt + 1;
            end
        end
        if (wr_t) begin
            last_w = n_edge;
            if (bus.addr == A_TCNT) m_tcnt = bus.wdata;
            else m_tlim = bus.wdata;
        end
        // status bits
        for (int i = 0; i < 3; i++) begin
            bit cw, dr, clr;
            cw  = bus.wr_en && bus.addr == CTRL_A[i];
            dr  = bus.rd_en && i < 2 && bus.addr == DATA_A[i];
            clr = dr || (cw && !bus.wdata[0]);
            if (cw && !bus.wdata[2]) m_ovr[i] = 1'b0;
            if (ev[i]) begin
                if (m_rdy[i] && !clr) m_ovr[i] = 1'b1;
                m_rdy[i] = 1'b1;
            end else if (clr) begin
                m_rdy[i] = 1'b0;
            end
            if (cw) m_ie[i] = bus.wdata[8];
        end
        if (bus.wr_en && bus.addr == A_HEX)  m_hex  = bus.wdata[15:0];
        if (bus.wr_en && bus.addr == A_LEDR) m_ledr = bus.wdata[9:0];
        if (bus.wr_en && bus.addr == A_LEDG) m_ledg = bus.wdata[7:0];
    endtask

    // Reference model advances on every rising edge
    always @(posedge clk) begin
        if (reset) begin
            n_edge = 0;
            last_w = 0;
            m_pr_last = '0;
            m_kd_cur = '0;
            m_kd_old = '0;
            sw_hist.delete();
            for (int i = 0; i < DEB + 2; i++) sw_hist.push_back('0);
            m_sdata = '0;
            m_tcnt = '0;
            m_tlim = '0;
            m_rdy = '0;
            m_ovr = '0;
            m_ie = '0;
            m_irq = 1'b0;
            m_hex = '0;
            m_ledr = '0;
            m_ledg = '0;
        end else begin
            model_step();
        end
    end

    // Monitor: pins every cycle, loads against the scoreboard queue
    always @(negedge clk) begin
        chk("hex_pin",  32'(hex),  32'(m_hex));
        chk("ledr_pin", 32'(ledr), 32'(m_ledr));
        chk("ledg_pin", 32'(ledg), 32'(m_ledg));
        chk("irq_pin",  32'(irq),  32'(m_irq));
        if (bus.rd_en) begin
            chk("rd_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("rdata@%h", e.a), bus.rdata, e.val);
                chk($sformatf("sel@%h", e.a), 32'(bus.sel), 32'(e.sel));
            end
        end
    end

    task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.rd_en = r;
        bus.wr_en = w;
        bus.addr  = a;
        bus.wdata = d;
        if (r) exp_q.push_back(model_read(a));
    endtask

    initial begin
        int op;
        logic [31:0] a, d;
        reset = 1'b1;
        key_in = '0;
        sw_in = '0;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;

        // reset with all keys held
        repeat (3) step(0, 0, 32'h0, 32'h0);
        step(1, 0, A_KDATA, 0);
        step(0, 0, 32'h0, 32'h0);
        reset = 1'b0;
        repeat (4) step(1, 0, A_KDATA, 0);
        step(1, 0, A_KCTRL, 0);
        step(1, 0, A_KDATA, 0);

        // output registers and unmapped access
        step(0, 1, A_HEX, 32'h1234);
        step(1, 0, A_HEX, 0);
        step(0, 1, A_LEDR, 32'hFFFF_FFFF);
        step(0, 1, A_LEDG, 32'h0000_01A5);
        step(1, 0, A_LEDR, 0);
        step(1, 0, A_LEDG, 0);
        step(0, 1, A_NONE, 32'hDEAD_BEEF);
        step(1, 0, A_NONE, 0);
        step(0, 1, A_KDATA, 32'h0);
        step(1, 0, A_KDATA, 0);

        // switch bounce then hold
        for (int i = 0; i < 4; i++) begin
            sw_in = (i % 2 == 0) ? 10'h001 : 10'h000;
            repeat (3) step(1, 0, A_SDATA, 0);
        end
        sw_in = 10'h001;
        repeat (14) step(1, 0, A_SDATA, 0);
        step(1, 0, A_SCTRL, 0);
        step(1, 0, A_SDATA, 0);
        step(1, 0, A_SCTRL, 0);

        // key events: overrun, clear by write, event coincident with read
        key_in = 4'hF;
        repeat (5) step(0, 0, 32'h0, 32'h0);
        step(0, 1, A_KCTRL, 32'h0);
        step(1, 0, A_KCTRL, 0);
        key_in = 4'hE;
        repeat (5) step(0, 0, 32'h0, 32'h0);
        key_in = 4'hC;
        repeat (5) step(0, 0, 32'h0, 32'h0);
        step(1, 0, A_KCTRL, 0);
        step(0, 1, A_KCTRL, 32'h5);
        step(1, 0, A_KCTRL, 0);
        step(0, 1, A_KCTRL, 32'h0);
        step(1, 0, A_KCTRL, 0);
        step(0, 0, 32'h0, 32'h0);
        key_in = 4'h8;
        step(0, 0, 32'h0, 32'h0);
        step(1, 0, A_KDATA, 0);
        step(1, 0, A_KCTRL, 0);

        // timer with interrupt
        step(0, 1, A_TCTRL, 32'h100);
        step(0, 1, A_TLIM, 32'd3);
        repeat (14) step(1, 0, A_TCNT, 0);
        step(1, 0, A_TCTRL, 0);
        step(0, 1, A_TCTRL, 32'h100);
        repeat (3) step(1, 0, A_TCTRL, 0);
        // timer write coincident with a tick
        step(0, 1, A_TLIM, 32'd3);
        repeat (3) step(1, 0, A_TCNT, 0);
        step(0, 1, A_TCNT, 32'd1);
        repeat (2) step(1, 0, A_TCNT, 0);
        step(0, 1, A_TLIM, 32'd0);
        repeat (3) step(1, 0, A_TCNT, 0);
        step(0, 1, A_TCNT, 32'd5);
        repeat (8) step(1, 0, A_TCNT, 0);
        step(1, 0, A_TLIM, 0);

        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            op = int'($urandom_range(0, 9));
            a = ADDRS[$urandom_range(0, 11)];
            d = $urandom();
            if (a == A_TCNT || a == A_TLIM) d = 32'($urandom_range(0, 6));
            if (op < 5)       step(1, 0, a, 0);
            else if (op < 7)  step(0, 1, a, d);
            else if (op == 7) step(1, 1, a, d);
            else              step(0, 0, a, 0);
            if ($urandom_range(0, 9) == 0)  key_in = KB'($urandom());
            if ($urandom_range(0, 24) == 0) sw_in = SWB'($urandom());
        end

        repeat (3) step(0, 0, 32'h0, 32'h0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mmio_io_controller.md
Name: mmio_io_controller

Overview:
- Parametrised memory-mapped I/O controller for the single-cycle CPU's data-memory I/O region; successor to the fixed KEY/SW/LEDR/LEDG/HEX mapping.
- Adds 2-flop synchronisers, switch debouncing, key change detection, and status/control registers with Ready/Overrun/IE bits.
- Adds a programmable millisecond timer and a combined interrupt output.
- Sits beside data memory; the CPU decodes the region with `sel`.

Parameters:
- DBITS, 32, data/address width.
- KEY_BITS, 4, number of push keys (raw inputs active-low).
- SW_BITS, 10, number of switches.
- LEDR_BITS, 10, red LED count.
- LEDG_BITS, 8, green LED count.
- HEX_DIGITS, 4, 7-seg digits; HEX register width is 4*HEX_DIGITS.
- DEBOUNCE_CYCLES, 100000, stable cycles required before a switch change is accepted.
- TICK_CYCLES, 50000, clocks per timer tick (1 ms at 50 MHz).
- ADDR_HEX/LEDR/LEDG, F0000000/F0000004/F0000008, output registers.
- ADDR_KDATA/KCTRL, F0000010/F0000110, key data/control.
- ADDR_SDATA/SCTRL, F0000014/F0000114, switch data/control.
- ADDR_TCNT/TLIM/TCTRL, F0000020/F0000024/F0000120, timer.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- addr  in  DBITS  byte address from ALU.
- wr_en  in  1  store strobe, applied at rising clk.
- rd_en  in  1  load strobe; read side effects applied at rising clk.
- wdata  in  DBITS  store data.
- rdata  out  DBITS  read data, combinational from addr.
- sel  out  1  addr matches a register in this block.
- irq  out  1  interrupt request.
- key_in  in  KEY_BITS  raw keys, active-low.
- sw_in  in  SW_BITS  raw switches.
- ledr  out  LEDR_BITS  red LEDs.
- ledg  out  LEDG_BITS  green LEDs.
- hex  out  4*HEX_DIGITS  nibbles to SevenSeg decoders.

Behaviour:
- Reset: ledr, ledg, hex, and all data, control, counter and limit registers = 0; irq = 0; synchroniser flops = 0. Reset mid-operation aborts any debounce or tick count immediately.
- Input sync: 2-flop synchroniser on every input bit; keys inverted after sync (pressed = 1).
- KDATA (RO) holds the synchronised pressed state.
  - Key change event = KDATA differs from its previous value.
  - Event sets KCTRL.Ready (bit0).
  - If Ready is already 1 and not being cleared this cycle, the event also sets Overrun (bit2).
- Switch debounce: a per-block counter restarts whenever the synchronised switch value differs from its last sample.
  - When the count reaches DEBOUNCE_CYCLES-1 and the value differs from SDATA, SDATA updates.
  - That update is the switch change event; SCTRL Ready/Overrun follow the same rules as keys.
- Control register write rules (KCTRL, SCTRL, TCTRL): bit0 and bit2 are write-0-to-clear; writing 1 to them is ignored. Bit8 = IE, read/write. Other bits read 0.
- Read side effect: rd_en to KDATA or SDATA clears the corresponding Ready the next edge. rdata returns the pre-edge value.
- Simultaneous event and clearing read/write: set wins. Ready stays 1 and Overrun is not set.
- Timer:
  - A prescaler counts 0..TICK_CYCLES-1; each wrap is one tick.
  - If TLIM != 0, each tick increments TCNT.
  - When TCNT == TLIM-1 at a tick, TCNT wraps to 0 and TCTRL.Ready sets (Overrun if already set).
  - TLIM == 0: TCNT holds.
  - A write to TCNT or TLIM loads the value and resets the prescaler to 0; the written value wins over a same-cycle tick.
- Output registers: HEX/LEDR/LEDG load wdata low bits on wr_en; reads return the zero-extended value.
- Data registers: writes to KDATA/SDATA are ignored.
- irq = OR over devices of (Ready & IE), registered (1-cycle latency from the Ready change).
- Address decode:
  - sel = 1 only on an exact match with a register address.
  - Unmapped address: rdata = 0, writes ignored.
  - rd_en/wr_en with sel = 0: no effect.
- Widths: all registers are right-aligned in DBITS and zero-extended.

Test Plan:
- Reset asserted with pins active (key_in=4'b0000) → all outputs 0. Release → KDATA=0xF after 2 cycles, KCTRL=0x1.
- Store 0x1234 to F0000000 → hex=0x1234 next edge; load F0000000 returns 0x00001234. Load F0000030 → rdata=0, sel=0.
- DEBOUNCE_CYCLES=8: sw_in bounces 0x001/0x000 every 3 cycles, then holds 0x001 → SDATA stays 0 during bounce, becomes 0x001 exactly 8 stable cycles after sync. SCTRL=0x1; load SDATA → SCTRL=0x0.
- Two key changes without a read → KCTRL=0x5. Write 0 to KCTRL → 0x0. Change coincident with a KDATA read → KCTRL=0x1.
- TICK_CYCLES=4, TLIM=3, TCTRL IE set → TCNT 0,1,2,0 every 4 clocks; Ready at first wrap; irq=1 one cycle later. Write TCTRL=0x100 → irq drops next+1 cycle.
- Write TLIM=0 → TCNT frozen. Write TCNT=5 in the same cycle as a tick → TCNT=5.
